trade_history: RTL and testbench

- Downstream consumer of the matching engine's trade stream.
- Captures each matched trade_price into a circular history buffer of the last DEPTH trades.
- Maintains windowed min/max statistics using a sequential scan FSM.
- Exposes a registered random-access read port for the VGA chart renderer and the HEX/LED display logic. Runs on clk_50.

---
 rtl/trade_history.sv | 164 ++++++++++++++++
 tb/tb_trade_history.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/trade_history.sv
// Trade price history: circular buffer of the last DEPTH trades, a scan FSM for min/max, and a registered read port.
// Optional build macro TRADE_HISTORY_AVG_EN adds a full-window average (avg_price/avg_valid).
module trade_history #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PRICE_W = 8
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               match_signal,
  input  logic [PRICE_W-1:0] trade_price,
  input  logic               halt_signal,
  input  logic [ADDR_W-1:0]  rd_index,
  output logic [PRICE_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [ADDR_W:0]    count,
  output logic [PRICE_W-1:0] last_price,
  output logic [PRICE_W-1:0] min_price,
  output logic [PRICE_W-1:0] max_price,
  output logic               stats_valid,
  output logic               overflow
`ifdef TRADE_HISTORY_AVG_EN
  ,
  output logic [PRICE_W-1:0] avg_price,
  output logic               avg_valid
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic logic [PRICE_W-1:0] price_min(input logic [PRICE_W-1:0] a,
                                                   input logic [PRICE_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [PRICE_W-1:0] price_max(input logic [PRICE_W-1:0] a,
                                                   input logic [PRICE_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  logic [PRICE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic               wr_en;

  state_t             state, state_nxt;
  logic               scan_done;
  logic [ADDR_W-1:0]  scan_idx;
  logic [ADDR_W-1:0]  scan_addr;
  logic [PRICE_W-1:0] scan_entry;
  logic [PRICE_W-1:0] tmp_min, tmp_max;
  logic [PRICE_W-1:0] fold_min, fold_max;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_hit;

  assign wr_en      = match_signal && !halt_signal;
  assign rd_addr    = wr_ptr - PTR_ONE - rd_index;
  assign rd_hit     = {1'b0, rd_index} < count;
  assign scan_addr  = wr_ptr - PTR_ONE - scan_idx;
  assign scan_entry = mem[scan_addr];
  assign fold_min   = price_min(tmp_min, scan_entry);
  assign fold_max   = price_max(tmp_max, scan_entry);

  // Buffer storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk_50) begin
    if (wr_en) mem[wr_ptr] <= trade_price;
  end

  // Write side: pointer, occupancy, last price, sticky overflow
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      count      <= '0;
      last_price <= '0;
      overflow   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr     <= wr_ptr + PTR_ONE;
      last_price <= trade_price;
      if (count == CNT_FULL) overflow <= 1'b1;
      else                   count    <= count + CNT_ONE;
    end
  end

  // Read stage: sampled against pre-write pointer and contents
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      rd_data  <= rd_hit ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A new write always wins over a scan finishing on the same edge.
  always_comb begin
    state_nxt = state;
    scan_done = 1'b0;
    if (wr_en) begin
      state_nxt = SCAN;
    end else if (state == SCAN && {1'b0, scan_idx} == count - CNT_ONE) begin
      state_nxt = IDLE;
      scan_done = 1'b1;
    end
  end

`ifdef TRADE_HISTORY_AVG_EN
  localparam int SUM_W = PRICE_W + ADDR_W;
  logic [SUM_W-1:0] sum, sum_nxt;
  assign sum_nxt = sum + SUM_W'(scan_entry);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sum       <= '0;
      avg_price <= '0;
      avg_valid <= 1'b0;
    end else if (wr_en) begin
      sum       <= '0;
      avg_valid <= 1'b0;
    end else if (state == SCAN) begin
      sum <= sum_nxt;
      if (scan_done) begin
        avg_valid <= (count == CNT_FULL);
        if (count == CNT_FULL) avg_price <= PRICE_W'(sum_nxt >> ADDR_W);
      end
    end
  end
`endif

  // Scan stage: fold one newest-relative entry per edge
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      scan_idx    <= '0;
      tmp_min     <= '1;
      tmp_max     <= '0;
      min_price   <= '0;
      max_price   <= '0;
      stats_valid <= 1'b0;
    end else if (wr_en) begin
      scan_idx    <= '0;
      tmp_min     <= '1;
      tmp_max     <= '0;
      stats_valid <= 1'b0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + PTR_ONE;
      tmp_min  <= fold_min;
      tmp_max  <= fold_max;
      if (scan_done) begin
        min_price   <= fold_min;
        max_price   <= fold_max;
        stats_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trade_history.sv
// Directed bench for trade_history: reset, read port, wrap, halt, back-to-back writes, mid-scan reset, optional average.
module tb_trade_history;

  localparam int DEPTH = 16, ADDR_W = 4, PRICE_W = 8;

  logic               clk_50 = 1'b0;
  logic               clk_run = 1'b0;
  logic               reset = 1'b0;
  logic               match_signal = 1'b0;
  logic [PRICE_W-1:0] trade_price = '0;
  logic               halt_signal = 1'b0;
  logic [ADDR_W-1:0]  rd_index = '0;
  logic [PRICE_W-1:0] rd_data;
  logic               rd_valid;
  logic [ADDR_W:0]    count;
  logic [PRICE_W-1:0] last_price, min_price, max_price;
  logic               stats_valid, overflow;
`ifdef TRADE_HISTORY_AVG_EN
  logic [PRICE_W-1:0] avg_price;
  logic               avg_valid;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #10 clk_50 = clk_run ? ~clk_50 : clk_50;

  trade_history #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRICE_W(PRICE_W)) dut (
    .clk_50(clk_50), .reset(reset), .match_signal(match_signal),
    .trade_price(trade_price), .halt_signal(halt_signal), .rd_index(rd_index),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .last_price(last_price),
    .min_price(min_price), .max_price(max_price), .stats_valid(stats_valid),
    .overflow(overflow)
`ifdef TRADE_HISTORY_AVG_EN
    , .avg_price(avg_price), .avg_valid(avg_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic write(input logic [PRICE_W-1:0] p);
    match_signal = 1'b1;
    trade_price  = p;
    tick();
    match_signal = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".rd_valid"}, 32'(rd_valid), 0);
    check({tag, ".rd_data"}, 32'(rd_data), 0);
    check({tag, ".stats_valid"}, 32'(stats_valid), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
    check({tag, ".last_price"}, 32'(last_price), 0);
    check({tag, ".min"}, 32'(min_price), 0);
    check({tag, ".max"}, 32'(max_price), 0);
  endtask

  initial begin
    // Reset with the clock stopped
    #5 reset = 1'b1;
    #1 check_all_zero("rst_noclk");
    clk_run = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();

    // Small sequence with idle cycles between writes
    write(8'd50); tick();
    write(8'd40); tick();
    write(8'd60);
    check("small.count", 32'(count), 3);
    check("small.last", 32'(last_price), 60);
    check("small.ovf", 32'(overflow), 0);
    rd_index = 4'd0; tick();
    check("small.rd0", 32'(rd_data), 60);
    check("small.rv0", 32'(rd_valid), 1);
    rd_index = 4'd1; tick();
    check("small.rd1", 32'(rd_data), 40);
    check("small.sv_early", 32'(stats_valid), 0);
    rd_index = 4'd2; tick();
    check("small.rd2", 32'(rd_data), 50);
    check("small.sv", 32'(stats_valid), 1);
    check("small.min", 32'(min_price), 40);
    check("small.max", 32'(max_price), 60);
    rd_index = 4'd3; tick();
    check("small.rv3", 32'(rd_valid), 0);
    check("small.rd3", 32'(rd_data), 0);

    // Wrap-around: 17 back-to-back writes of 1..17 on top of 3 entries
    for (int i = 1; i <= 17; i++) write(8'(i));
    check("wrap.count", 32'(count), 16);
    check("wrap.ovf", 32'(overflow), 1);
    rd_index = 4'd15; tick();
    check("wrap.rd15", 32'(rd_data), 2);
    rd_index = 4'd0; tick();
    check("wrap.rd0", 32'(rd_data), 17);
    tick(13);
    check("wrap.sv_15", 32'(stats_valid), 0);
    tick();
    check("wrap.sv_16", 32'(stats_valid), 1);
    check("wrap.min", 32'(min_price), 2);
    check("wrap.max", 32'(max_price), 17);

    // Halt while idle: everything frozen
    halt_signal = 1'b1;
    match_signal = 1'b1; trade_price = 8'd99;
    tick(3);
    match_signal = 1'b0;
    check("halt.count", 32'(count), 16);
    check("halt.last", 32'(last_price), 17);
    check("halt.rd0", 32'(rd_data), 17);
    check("halt.sv", 32'(stats_valid), 1);
    check("halt.max", 32'(max_price), 17);

    // Scan started by a write completes while halted
    halt_signal = 1'b0;
    write(8'd200);
    halt_signal = 1'b1;
    match_signal = 1'b1; trade_price = 8'd99;
    tick(15);
    check("halt_scan.sv_15", 32'(stats_valid), 0);
    tick();
    check("halt_scan.sv_16", 32'(stats_valid), 1);
    check("halt_scan.min", 32'(min_price), 3);
    check("halt_scan.max", 32'(max_price), 200);
    check("halt_scan.last", 32'(last_price), 200);
    match_signal = 1'b0;
    halt_signal = 1'b0;
    tick();

    // Reset asserted mid-scan, asynchronously
    write(8'd42);
    tick(3);
    #3 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back writes after reset
    write(8'd9);
    check("b2b.sv1", 32'(stats_valid), 0);
    write(8'd3);
    check("b2b.sv2", 32'(stats_valid), 0);
    write(8'd7);
    write(8'd8);
    write(8'd5);
    check("b2b.count", 32'(count), 5);
    rd_index = 4'd4; tick();
    check("b2b.rd4", 32'(rd_data), 9);
    rd_index = 4'd5; tick();
    check("b2b.rv5", 32'(rd_valid), 0);
    tick(2);
    check("b2b.sv_4", 32'(stats_valid), 0);
    tick();
    check("b2b.sv_5", 32'(stats_valid), 1);
    check("b2b.min", 32'(min_price), 3);
    check("b2b.max", 32'(max_price), 9);
    check("b2b.ovf", 32'(overflow), 0);

`ifdef TRADE_HISTORY_AVG_EN
    check("avg.partial_valid", 32'(avg_valid), 0);
    for (int i = 0; i < 16; i++) write(8'd10);
    check("avg.cleared", 32'(avg_valid), 0);
    tick(16);
    check("avg.valid", 32'(avg_valid), 1);
    check("avg.price", 32'(avg_price), 10);
    check("avg.min", 32'(min_price), 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: observed running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
